// File: rtl/host_ni_if.sv
// Router local-port flit channel: request flits toward the router, reply flits back.
interface host_ni_if #(parameter int DATAW = 32);
  logic [DATAW+1:0] odata;
  logic             ovalid;
  logic             ovch;
  logic [1:0]       irdy;
  logic [DATAW+1:0] idata;
  logic             ivalid;

  modport master (output odata, ovalid, ovch, input irdy, idata, ivalid);
  modport slave  (input odata, ovalid, ovch, output irdy, idata, ivalid);
endinterface

// File: rtl/host_ni.sv
// Host network interface: injects a burst of request packets over two VCs and
// absorbs/counts the replies, flagging framing errors and reply timeouts.
module host_ni #(
  parameter int DATAW   = 32,
  parameter int PKT_LEN = 4,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 8,
  parameter int TMO     = 1024
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic [ID_W-1:0]  dst_id,
  input  logic [ID_W-1:0]  src_id,
  input  logic [CNT_W-1:0] num_pkts,
  host_ni_if.master        nif,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [1:0]       err
);
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int TMR_W = $clog2(TMO + 1);
  localparam logic [1:0] F_BODY = 2'b00, F_HEAD = 2'b01, F_TAIL = 2'b10;

  typedef enum logic [2:0] {IDLE, VSEL, SEND, WAIT, DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  dst_r;
  logic [CNT_W-1:0] num_r;
  logic [IDX_W-1:0] idx;
  logic             cur_vc, ptr, in_pkt;
  logic [TMR_W-1:0] tmr;
  logic [DATAW+1:0] odata_r;
  logic             ovch_r;

  logic [1:0]       ityp;
  logic             vsel_ch, last;
  logic [CNT_W-1:0] sent_nx, recv_nx;
  logic             unused_payload;

  // Head carries routing ids + sequence; body/tail carry {flit index, seq} for tracing.
  function automatic logic [DATAW+1:0] mk_flit(input logic [IDX_W-1:0] i,
                                               input logic [CNT_W-1:0] seq,
                                               input logic [ID_W-1:0]  dst,
                                               input logic [ID_W-1:0]  src);
    logic [1:0]       t;
    logic [DATAW-1:0] p;
    if (i == '0) p = DATAW'({seq, src, dst});
    else         p = DATAW'({8'(i), 8'(seq)});
    if (PKT_LEN == 1)                  t = 2'b11;
    else if (i == '0)                  t = F_HEAD;
    else if (i == IDX_W'(PKT_LEN - 1)) t = F_TAIL;
    else                               t = F_BODY;
    return {t, p};
  endfunction

  assign ityp           = nif.idata[DATAW+1:DATAW];
  assign unused_payload = ^nif.idata[DATAW-1:0];
  assign vsel_ch        = nif.irdy[ptr] ? ptr : ~ptr;
  assign last           = (idx == IDX_W'(PKT_LEN - 1));
  assign sent_nx        = sent_cnt + 1'b1;
  assign recv_nx        = (&recv_cnt) ? recv_cnt : recv_cnt + 1'b1;

  assign nif.odata  = odata_r;
  assign nif.ovch   = ovch_r;
  assign nif.ovalid = (state == SEND) && nif.irdy[cur_vc];
  assign busy       = (state == VSEL) || (state == SEND) || (state == WAIT);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      odata_r  <= '0;
      ovch_r   <= 1'b0;
      cur_vc   <= 1'b0;
      ptr      <= 1'b0;
      idx      <= '0;
      dst_r    <= '0;
      num_r    <= '0;
      sent_cnt <= '0;
      recv_cnt <= '0;
      err      <= '0;
      in_pkt   <= 1'b0;
      tmr      <= '0;
    end else begin
      // Reply side runs independently of the TX state; a start below overrides its clears.
      if (nif.ivalid) begin
        if (recv_cnt == num_r) err[0] <= 1'b1;
        case (ityp)
          F_HEAD: begin
            if (in_pkt) err[0] <= 1'b1;
            in_pkt <= 1'b1;
          end
          F_BODY: if (!in_pkt) err[0] <= 1'b1;
          F_TAIL: begin
            if (!in_pkt) err[0] <= 1'b1;
            else begin
              recv_cnt <= recv_nx;
              in_pkt   <= 1'b0;
            end
          end
          default: begin
            if (in_pkt) err[0] <= 1'b1;
            recv_cnt <= recv_nx;
            in_pkt   <= 1'b0;
          end
        endcase
      end

      case (state)
        IDLE, DONE: if (start) begin
          dst_r <= dst_id;
          num_r <= num_pkts;
          if (num_pkts == '0) state <= DONE;
          else begin
            sent_cnt <= '0;
            recv_cnt <= '0;
            err      <= '0;
            state    <= VSEL;
          end
        end
        VSEL: if (|nif.irdy) begin
          cur_vc  <= vsel_ch;
          ovch_r  <= vsel_ch;
          ptr     <= ~vsel_ch;
          idx     <= '0;
          odata_r <= mk_flit('0, sent_cnt, dst_r, src_id);
          state   <= SEND;
        end
        SEND: if (nif.ovalid) begin
          if (last) begin
            sent_cnt <= sent_nx;
            tmr      <= '0;
            state    <= (sent_nx == num_r) ? WAIT : VSEL;
          end else begin
            idx     <= idx + 1'b1;
            odata_r <= mk_flit(idx + 1'b1, sent_cnt, dst_r, src_id);
          end
        end
        WAIT: begin
          if (recv_cnt == num_r) state <= DONE;
          else if (nif.ivalid) tmr <= '0;
          else if (tmr == TMR_W'(TMO - 1)) begin
            err[1] <= 1'b1;
            state  <= DONE;
          end else tmr <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_host_ni.sv
// Bench for host_ni: directed scenarios plus randomized bursts, checked against
// a flit-list model built from the packet format rules.
module tb_host_ni;
  localparam int DATAW = 32, PKT_LEN = 4, ID_W = 4, CNT_W = 8, TMO = 64;
  localparam int W = DATAW + 2;
  localparam int SRC = 1;

  logic             clk = 1'b0, rst_ = 1'b0, start = 1'b0;
  logic [ID_W-1:0]  dst_id = '0, src_id = ID_W'(SRC);
  logic [CNT_W-1:0] num_pkts = '0;
  logic             busy, done;
  logic [CNT_W-1:0] sent_cnt, recv_cnt;
  logic [1:0]       err;

  host_ni_if #(.DATAW(DATAW)) nif();

  host_ni #(.DATAW(DATAW), .PKT_LEN(PKT_LEN), .ID_W(ID_W), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .clk(clk), .rst_(rst_), .start(start), .dst_id(dst_id), .src_id(src_id),
    .num_pkts(num_pkts), .nif(nif), .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int         n_pass = 0, n_chk = 0, cyc = 0, tx_n = 0;
  int         tx_cyc[$];
  logic [W-1:0] exp_q[$];
  logic       exp_vc[$];
  logic [W-1:0] rq[$];
  bit         auto_rep = 1'b0;
  logic       pkt_vc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] exp_flit(input int seq, input int i, input int dst);
    logic [1:0] t;
    int p;
    if (i == 0) p = dst + SRC * 16 + seq * 256;
    else        p = (seq % 256) + i * 256;
    if (PKT_LEN == 1)          t = 2'b11;
    else if (i == 0)           t = 2'b01;
    else if (i == PKT_LEN - 1) t = 2'b10;
    else                       t = 2'b00;
    return {t, 32'(p)};
  endfunction

  task automatic kick(input int dst, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(exp_flit(p, i, dst));
    dst_id = ID_W'(dst); num_pkts = CNT_W'(n); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin @(posedge clk); #1; k++; end
    chk(tag, done, 1);
  endtask

  task automatic wait_sent(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (sent_cnt != CNT_W'(n) && k < budget) begin @(posedge clk); #1; k++; end
    chk(tag, sent_cnt, n);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: scoreboards every flit, VC stickiness, and queues auto replies.
  always @(negedge clk) begin
    if (rst_ && nif.ovalid) begin
      tx_n++;
      tx_cyc.push_back(cyc);
      chk("tx_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("flit", nif.odata, exp_q.pop_front());
      chk("tx_rdy", nif.irdy[nif.ovch], 1);
      if (nif.odata[W-2]) begin
        pkt_vc = nif.ovch;
        if (exp_vc.size() > 0) chk("head_vc", nif.ovch, exp_vc.pop_front());
      end else chk("vc_hold", nif.ovch, pkt_vc);
      if (auto_rep && nif.odata[W-1]) rq.push_back({2'b11, 32'h0});
    end
  end

  // Reply driver: one queued flit per cycle, randomly spaced.
  initial begin
    nif.ivalid = 1'b0;
    nif.idata  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_ && rq.size() > 0 && $urandom_range(0, 1) == 1) begin
        nif.idata  = rq.pop_front();
        nif.ivalid = 1'b1;
      end else begin
        nif.ivalid = 1'b0;
        nif.idata  = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b, k, n, d;
    nif.irdy = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovalid", nif.ovalid, 0);
    chk("rst_odata", nif.odata, 0);
    chk("rst_ovch", nif.ovch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnts", {sent_cnt, recv_cnt}, 0);
    chk("rst_err", err, 0);
    rst_ = 1'b1;
    @(posedge clk); #1;

    // Two back-to-back packets on alternating VCs
    auto_rep = 1'b1;
    b = tx_cyc.size();
    exp_vc.push_back(1'b0); exp_vc.push_back(1'b1);
    kick(5, 2);
    wait_done("t1_done", 300);
    chk("t1_nflits", tx_cyc.size() - b, 8);
    if (tx_cyc.size() - b == 8)
      for (int i = 1; i < 8; i++) chk("t1_gap", tx_cyc[b+i] - tx_cyc[b+i-1], (i == 4) ? 2 : 1);
    chk("t1_sent", sent_cnt, 2);
    chk("t1_recv", recv_cnt, 2);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);

    // Zero-length burst goes straight to DONE and keeps counters
    kick(6, 0);
    chk("zero_busy", busy, 0);
    chk("zero_done", done, 1);
    chk("zero_sent", sent_cnt, 2);

    // Backpressure on the active VC mid-packet
    exp_vc.push_back(1'b0);
    b = tx_n;
    kick(9, 1);
    k = 0;
    while (tx_n < b + 2 && k < 50) begin @(posedge clk); #1; k++; end
    chk("t2_reach", tx_n - b, 2);
    nif.irdy = 2'b10;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_valid", nif.ovalid, 0);
      chk("t2_hold", nif.odata, exp_flit(0, 2, 9));
      chk("t2_vc", nif.ovch, 0);
      @(posedge clk); #1;
    end
    nif.irdy = 2'b11;
    wait_done("t2_done", 200);
    chk("t2_nflits", tx_n - b, 4);
    chk("t2_err", err, 0);

    // No VC ready: hold in VC select, then go out on VC1
    nif.irdy = 2'b00;
    exp_vc.push_back(1'b1);
    b = tx_n;
    kick(3, 1);
    repeat (5) begin
      @(negedge clk);
      chk("t3_idle_valid", nif.ovalid, 0);
      chk("t3_busy", busy, 1);
      @(posedge clk); #1;
    end
    nif.irdy = 2'b10;
    wait_done("t3_done", 200);
    chk("t3_nflits", tx_n - b, 4);

    // Body flit with no head is a framing error and is not counted
    nif.irdy = 2'b11;
    auto_rep = 1'b0;
    kick(2, 1);
    wait_sent("t4_sent", 1, 100);
    rq.push_back({2'b00, 32'h0});
    k = 0;
    while (!err[0] && k < 50) begin @(posedge clk); #1; k++; end
    chk("t4_err", err, 2'b01);
    chk("t4_recv", recv_cnt, 0);
    rq.push_back({2'b11, 32'h0});
    wait_done("t4_done", 200);
    chk("t4_err_sticky", err, 2'b01);
    chk("t4_recv_end", recv_cnt, 1);

    // Start clears err; missing reply times out
    kick(4, 1);
    chk("t5_err_clr", err, 0);
    wait_sent("t5_sent", 1, 100);
    k = 0;
    while (!done && k < TMO + 20) begin @(posedge clk); #1; k++; end
    chk("t5_done", done, 1);
    chk("t5_lat", (k >= TMO && k <= TMO + 2), 1);
    chk("t5_err", err, 2'b10);
    chk("t5_recv", recv_cnt, 0);

    // Asynchronous reset in the middle of the second packet
    auto_rep = 1'b1;
    b = tx_n;
    kick(8, 3);
    k = 0;
    while (tx_n < b + 6 && k < 100) begin @(posedge clk); #1; k++; end
    chk("t6_reach", tx_n - b, 6);
    #2 rst_ = 1'b0;
    #1;
    chk("t6_ovalid", nif.ovalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sent", sent_cnt, 0);
    chk("t6_recv", recv_cnt, 0);
    chk("t6_odata", nif.odata, 0);
    exp_q.delete(); rq.delete(); exp_vc.delete();
    @(posedge clk); #1;
    rst_ = 1'b1;
    exp_vc.push_back(1'b0);
    b = tx_n;
    kick(7, 1);
    wait_done("t6_done", 200);
    chk("t6_nflits", tx_n - b, 4);
    chk("t6_cnts", {sent_cnt, recv_cnt}, {8'd1, 8'd1});
    chk("t6_err", err, 0);

    // Randomized bursts with random per-VC readiness and reply timing
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      d = $urandom_range(0, 15);
      kick(d, n);
      k = 0;
      while (!done && k < 2000) begin
        nif.irdy = 2'($urandom_range(0, 3));
        @(posedge clk); #1; k++;
      end
      chk("rnd_done", done, 1);
      chk("rnd_sent", sent_cnt, n);
      chk("rnd_recv", recv_cnt, n);
      chk("rnd_err", err, 0);
      chk("rnd_left", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/host_ni.md
Name: host_ni

Overview:
- Host-side network interface that sits on a router local port, opposite a PE.
- Injects a programmed burst of request packets (head/body/tail flits) toward one destination PE over 2 virtual channels.
- Absorbs the reply packets the PE returns and reports completion, counts and protocol/timeout errors.
- Used by the cycle-simulation testbench as the traffic initiator for PE-cycle measurements.

Parameters:
- DATAW, 32: flit payload width; a flit is DATAW+2 bits (2-bit type field on top).
- PKT_LEN, 4: flits per request packet, ≥1; 1 means single head-tail flit.
- ID_W, 4: node id width.
- CNT_W, 8: packet counter width.
- TMO, 1024: idle cycles in WAIT before timeout error.

Ports:
- clk  in  1  clock.
- rst_  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; launches a burst; ignored unless state is IDLE or DONE.
- dst_id  in  ID_W  destination PE id; sampled on start.
- src_id  in  ID_W  own id; static.
- num_pkts  in  CNT_W  requests in burst; sampled on start; 0 goes straight to DONE.
- odata  out  DATAW+2  flit to router.
- ovalid  out  1  flit transfer this cycle.
- ovch  out  1  VC index of odata (0/1).
- irdy  in  2  per-VC ready from router local input port.
- idata  in  DATAW+2  reply flit from router.
- ivalid  in  1  reply flit valid; always accepted, no backpressure.
- busy  out  1  state not IDLE/DONE.
- done  out  1  high in DONE.
- sent_cnt  out  CNT_W  request packets fully sent (tails transferred).
- recv_cnt  out  CNT_W  reply packets fully received.
- err  out  2  sticky: [0] protocol error, [1] timeout.

Behaviour:
- Flit type in bits [DATAW+1:DATAW]: 01 head, 00 body, 10 tail, 11 head-tail.
- Head payload: {dst_id, src_id, seq} packed LSB-first, seq = sent_cnt, zero-extended. Body/tail payload: {seq[7:0], flit index} packed the same way, remaining bits zero.
- Reset: state IDLE; odata 0, ovalid 0, ovch 0, counters 0, err 0, busy 0, done 0; internal VC pointer 0.
- TX FSM states: IDLE, VSEL, SEND, WAIT, DONE.
- IDLE/DONE, start=1: latch dst/num. If num_pkts==0 go to DONE. Otherwise clear counters and err, then go to VSEL.
- VSEL: choose VC round-robin starting at the pointer, among VCs with irdy=1. The chosen VC is latched and the pointer becomes chosen+1. If neither VC is ready, stay in VSEL. Next state is SEND with flit index 0.
- SEND: ovalid = irdy[cur_vc], combinational; odata/ovch are registered and stable for the whole packet flit. A cycle with ovalid=1 is a transfer: the flit index advances and odata loads the next flit. While irdy[cur_vc]=0, ovalid=0 and odata holds. The VC is held for the entire packet; no interleaving.
- Tail transfer: sent_cnt+1. If sent_cnt+1 == num_pkts go to WAIT, else go to VSEL. Minimum 1 idle cycle between packets (the VSEL cycle).
- RX (concurrent with TX): a receive-side in_pkt flag tracks packet framing.
  - head: set in_pkt.
  - body/tail with in_pkt=0: err[0] set.
  - head while in_pkt=1: err[0] set.
  - tail or head-tail accepted: recv_cnt+1, clear in_pkt.
  - recv_cnt saturates at all-ones.
  - A reply received when recv_cnt == num_pkts sets err[0].
- WAIT: exit to DONE when recv_cnt == num_pkts. The timer resets on every ivalid; reaching TMO sets err[1] and goes to DONE.
- Replies may arrive in SEND/VSEL and are counted immediately. If all replies are already counted on entry to WAIT, go to DONE next cycle.
- DONE: done=1, outputs hold; start restarts.
- start while busy: ignored.
- Async reset mid-packet: everything returns to reset values immediately; a partial packet is abandoned.

Test Plan:
- num_pkts=2, PKT_LEN=4, irdy=11 always, dst=5, src=1: 8 back-to-back flits with 1-cycle gap between packets, types 01,00,00,10 each; ovch=0 then 1. The bench returns 2 head-tail replies; done=1 with sent_cnt=2, recv_cnt=2, err=00.
- irdy[0] toggled low for 3 cycles mid-packet on VC0: ovalid=0 for exactly those cycles, odata unchanged, no VC switch, and the packet completes with 4 transfers.
- irdy=00 for 5 cycles after start: state stays VSEL and ovalid=0; irdy=10 is then raised and the first head goes out with ovch=1.
- Reply with a body flit and no head (ivalid, type 00): err[0]=1 sticky, recv_cnt unchanged. A later start clears err.
- num_pkts=1 with no reply: err[1]=1 after TMO idle cycles in WAIT, then done=1 and recv_cnt=0.
- rst_ asserted asynchronously during flit 2 of a packet: ovalid, busy and counters go to 0 without waiting for a clock edge. A new start after release sends a fresh head with seq=0 on VC0.
